// File: rtl/fp_pkg.sv
// fp_pkg: IEEE-754 single-precision field widths, bias and value classes
// shared by the float-handling blocks.
package fp_pkg;
    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int FP32_BIAS  = 127;
    typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_t;
endpackage

// File: rtl/fp_to_fixed_conv_if.sv
// fp_to_fixed_conv_if: float input stream and fixed-point output stream,
// both valid/ready, as seen by the converter (slave) and its neighbours (master).
interface fp_to_fixed_conv_if #(parameter int OUT_W = 24);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;
    logic             out_nan;
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, out_ovf, out_nan);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, out_ovf, out_nan);
endinterface

// File: rtl/fp32_classify.sv
// fp32_classify: splits an IEEE-754 single into sign, exponent and hidden-bit
// significand, and classifies it (denormals are treated as zero).
module fp32_classify
    import fp_pkg::*;
(
    input  logic [31:0]           data_i,
    output logic                  sign_o,
    output logic [FP32_EXP_W-1:0] exp_o,
    output logic [FP32_MAN_W:0]   mant_ext_o,
    output fp_class_t             cls_o
);
    logic [FP32_MAN_W-1:0] man;
    assign sign_o     = data_i[31];
    assign exp_o      = data_i[30 -: FP32_EXP_W];
    assign man        = data_i[FP32_MAN_W-1:0];
    assign mant_ext_o = {|exp_o, man};
    assign cls_o      = (exp_o == '0) ? FP_ZERO :
                        (&exp_o) ? ((man != '0) ? FP_NAN : FP_INF) : FP_NORM;
endmodule

// File: rtl/fp_to_fixed_conv.sv
// fp_to_fixed_conv: 3-stage float -> signed fixed-point converter (classify, align, round/saturate).
// Define FP2FIX_ROUND_EN for round-to-nearest-even; otherwise the magnitude is truncated.
module fp_to_fixed_conv
    import fp_pkg::*;
#(
    parameter int OUT_W     = 24,
    parameter int FRAC_BITS = 22
)(
    input logic               clk,
    input logic               reset,
    fp_to_fixed_conv_if.slave bus
);
    localparam int M_W = FP32_MAN_W + 1;
    localparam logic signed [9:0] SH_OFS  = 10'(FP32_BIAS + FP32_MAN_W - FRAC_BITS);
    localparam logic signed [9:0] MAX_LSH = 10'(OUT_W - M_W);
    localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_MAX = {1'b1, {(OUT_W-1){1'b0}}};

    logic en;
    logic                  s1_sign_d, s1_valid_q, s1_sign_q;
    logic [FP32_EXP_W-1:0] s1_exp_d, s1_exp_q;
    logic [M_W-1:0]        s1_mant_d, s1_mant_q;
    fp_class_t             s1_cls_d, s1_cls_q;
    logic                  s2_valid_q, s2_sign_q, s2_ovf_d, s2_ovf_q, s2_nan_d, s2_nan_q;
    logic [OUT_W-1:0]      s2_mag_d, s2_mag_q;
    logic                  out_valid_q, out_ovf_d, out_ovf_q, out_nan_q;
    logic [OUT_W-1:0]      out_data_d, out_data_q;
    logic signed [9:0]     sh;
    logic [9:0]            rs;
    logic [M_W-1:0]        rmag;
    logic [OUT_W:0]        mag_r;
    logic                  inc;

    assign en           = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_nan   = out_nan_q;

    fp32_classify u_cls (
        .data_i     (bus.in_data),
        .sign_o     (s1_sign_d),
        .exp_o      (s1_exp_d),
        .mant_ext_o (s1_mant_d),
        .cls_o      (s1_cls_d)
    );

    // sh is the left-shift that puts the significand LSB onto the output LSB grid
    assign sh = $signed({2'b00, s1_exp_q}) - SH_OFS;
    assign rs = -sh;

`ifdef FP2FIX_ROUND_EN
    localparam int RS_W = M_W + 2;
    localparam logic [9:0] RS_LIM = 10'(RS_W);
    logic [M_W+RS_W-1:0] wide;
    logic                rsh_ok, s2_guard_d, s2_sticky_d, s2_guard_q, s2_sticky_q;
    always_comb begin
        wide        = {s1_mant_q, {RS_W{1'b0}}} >> rs;
        rmag        = wide[M_W+RS_W-1:RS_W];
        rsh_ok      = (s1_cls_q == FP_NORM) && sh[9];
        s2_guard_d  = rsh_ok && (rs < RS_LIM) && wide[RS_W-1];
        s2_sticky_d = rsh_ok && ((rs >= RS_LIM) || (|wide[RS_W-2:0]));
    end
    assign inc = s2_guard_q & (s2_sticky_q | s2_mag_q[0]);
`else
    assign rmag = s1_mant_q >> rs;
    assign inc  = 1'b0;
`endif

    always_comb begin
        s2_nan_d = s1_cls_q == FP_NAN;
        s2_ovf_d = (s1_cls_q == FP_INF) || ((s1_cls_q == FP_NORM) && (sh > MAX_LSH));
        s2_mag_d = ((s1_cls_q != FP_NORM) || s2_ovf_d) ? '0 :
                   sh[9] ? OUT_W'(rmag) : OUT_W'(s1_mant_q) << sh;
    end

    // negative side reaches one LSB further than positive, so the limit depends on sign
    always_comb begin
        mag_r      = {1'b0, s2_mag_q} + (OUT_W+1)'(inc);
        out_ovf_d  = s2_ovf_q | (mag_r > {1'b0, s2_sign_q ? NEG_MAX : POS_MAX});
        out_data_d = s2_nan_q ? '0 :
                     out_ovf_d ? (s2_sign_q ? NEG_MAX : POS_MAX) :
                     s2_sign_q ? -mag_r[OUT_W-1:0] : mag_r[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_mant_q   <= '0;
            s1_cls_q    <= FP_ZERO;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_ovf_q    <= 1'b0;
            s2_nan_q    <= 1'b0;
            s2_mag_q    <= '0;
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_nan_q   <= 1'b0;
            out_data_q  <= '0;
        end else if (en) begin
            s1_valid_q  <= bus.in_valid;
            s1_sign_q   <= s1_sign_d;
            s1_exp_q    <= s1_exp_d;
            s1_mant_q   <= s1_mant_d;
            s1_cls_q    <= s1_cls_d;
            s2_valid_q  <= s1_valid_q;
            s2_sign_q   <= s1_sign_q;
            s2_ovf_q    <= s2_ovf_d;
            s2_nan_q    <= s2_nan_d;
            s2_mag_q    <= s2_mag_d;
            out_valid_q <= s2_valid_q;
            out_ovf_q   <= out_ovf_d;
            out_nan_q   <= s2_nan_q;
            out_data_q  <= out_data_d;
        end
    end

`ifdef FP2FIX_ROUND_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_guard_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
        end else if (en) begin
            s2_guard_q  <= s2_guard_d;
            s2_sticky_q <= s2_sticky_d;
        end
    end
`endif
endmodule
